// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Build option MULDIV_FAST_MUL_EN is consumed by the datapath and top, not here.
package cpu_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

    localparam logic [MD_XLEN-1:0] DIV0_QUOT = '1;
    localparam logic [MD_XLEN-1:0] INT_MIN   = 32'h8000_0000;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/write-back bundle between the core pipeline and the multiply/divide unit.
interface mul_div_unit_if #(parameter int XLEN = 32);

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [4:0]      rd_addr;
    logic            flush;

    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      wb_addr;
    logic            wb_we;

    modport master (
        output start, op, rs1_data, rs2_data, rd_addr, flush,
        input  busy, stall, done, result, wb_addr, wb_we
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_addr, flush,
        output busy, stall, done, result, wb_addr, wb_we
    );

endinterface

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers, one-bit shift-add / restoring-divide step and sign fix-up.
// MULDIV_FAST_MUL_EN: multiplies load the full product at accept instead of iterating.
module muldiv_datapath
    import cpu_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            fix_i,
    input  muldiv_op_e      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            early_o,
    output logic [XLEN-1:0] result_o
);

    muldiv_op_e      op_q;
    logic            neg_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] acc_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] result_q;

    logic            a_neg, b_neg, res_neg;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, ovf;
    logic [XLEN-1:0] early_val;

    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        case (op_i)
            MULH, DIV, REM: begin
                a_neg = a_i[XLEN-1];
                b_neg = b_i[XLEN-1];
            end
            MULHSU:  a_neg = a_i[XLEN-1];
            default: ;
        endcase
        // Quotient and MULH signs combine both operands; REM and MULHSU follow rs1 only.
        res_neg = (op_i == MULH || op_i == DIV) ? (a_neg ^ b_neg) : a_neg;
        abs_a   = a_neg ? -a_i : a_i;
        abs_b   = b_neg ? -b_i : b_i;
    end

    always_comb begin
        div_zero  = op_is_div(op_i) & (b_i == '0);
        ovf       = (op_i == DIV || op_i == REM) & (a_i == INT_MIN) & (b_i == '1);
        early_o   = div_zero | ovf;
        early_val = '0;
        if (div_zero)
            early_val = op_is_rem(op_i) ? a_i : DIV0_QUOT;
        else if (ovf)
            early_val = op_is_rem(op_i) ? '0 : INT_MIN;
    end

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_shift;
    logic [XLEN:0] div_diff;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
        rem_shift = {acc_q, lo_q[XLEN-1]};
        // Top bit is the borrow: set only when the shifted remainder is below the divisor.
        div_diff  = rem_shift - {1'b0, mcand_q};
    end

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

    always_comb begin
        prod     = {acc_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        quot_fix = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -acc_q : acc_q;
        case (op_q)
            MUL:                 fix_val = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_val = quot_fix;
            default:             fix_val = rem_fix;
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= MUL;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            if (load_i) begin
                op_q    <= op_i;
                neg_q   <= res_neg;
                mcand_q <= abs_b;
                acc_q   <= '0;
                lo_q    <= abs_a;
`ifdef MULDIV_FAST_MUL_EN
                if (!op_is_div(op_i))
                    {acc_q, lo_q} <= fast_prod;
`endif
                if (early_o)
                    result_q <= early_val;
            end else if (step_i) begin
                if (op_is_div(op_q)) begin
                    if (div_diff[XLEN]) begin
                        acc_q <= rem_shift[XLEN-1:0];
                        lo_q  <= {lo_q[XLEN-2:0], 1'b0};
                    end else begin
                        acc_q <= div_diff[XLEN-1:0];
                        lo_q  <= {lo_q[XLEN-2:0], 1'b1};
                    end
                end else begin
                    acc_q <= mul_sum[XLEN:1];
                    lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
                end
            end
            if (fix_i)
                result_q <= fix_val;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/mul_div_unit.sv
// RV32M multi-cycle execute unit: FSM, iteration counter, handshake and write-back outputs.
// MULDIV_FAST_MUL_EN: multiplies skip CALC (IDLE -> FIX -> DONE).
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide bit per cycle
// FIX   | sign correction and result select
// DONE  | done pulse; may accept the next op
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int XLEN      = MD_XLEN,
    parameter int ITER_BITS = 6
) (
    input logic           clk,
    input logic           reset,
    mul_div_unit_if.slave bus
);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    muldiv_state_e        state_q, state_d;
    logic [ITER_BITS-1:0] cnt_q, cnt_d;
    logic [4:0]           wb_addr_q;

    muldiv_op_e op;
    logic       accept, load, step, fix, early;

    assign op     = muldiv_op_e'(bus.op);
    assign accept = bus.start & ~bus.flush & (state_q == IDLE || state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    if (early)
                        state_d = DONE;
                    else if (FAST_MUL && !op_is_div(op))
                        state_d = FIX;
                    else
                        state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ITER_BITS'(XLEN-1))
                    state_d = FIX;
            end
            FIX: begin
                // A flushed op must not overwrite the held result.
                fix     = ~bus.flush;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wb_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load)
                wb_addr_q <= bus.rd_addr;
        end
    end

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .fix_i    (fix),
        .op_i     (op),
        .a_i      (bus.rs1_data),
        .b_i      (bus.rs2_data),
        .early_o  (early),
        .result_o (bus.result)
    );

    assign bus.busy    = (state_q == CALC) || (state_q == FIX);
    assign bus.done    = (state_q == DONE);
    assign bus.stall   = (bus.start & ~accept) | bus.busy;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_we   = bus.done & (wb_addr_q != 5'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed RV32M cases, control cases and random ops.
module tb_mul_div_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32), .ITER_BITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = '0;
        r  = '0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 2;
`endif
        return 34;
    endfunction

    // Issue one op now (IDLE or DONE), optionally poke a start at cycle inj_k, check the write-back.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int inj_k);
        int k;
        bit seen;
        int lat;
        lat = exp_lat(op, a, b);
        bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd; bus.start = 1'b1;
        #1 chk({tag, " stall_at_accept"}, bus.stall, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, " busy_after_accept"}, bus.busy, (lat > 1));
        k = 0;
        seen = 1'b0;
        while (!seen && k < 60) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (k == inj_k) begin
                    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_data = 32'h1234; bus.rs2_data = 32'd3; bus.rd_addr = 5'd9;
                    #1 chk({tag, " stall_on_ignored_start"}, bus.stall, 1);
                end
                @(posedge clk); #1;
                bus.start = 1'b0;
                k++;
            end
        end
        chk({tag, " latency"}, seen ? k + 1 : 0, lat);
        if (seen) begin
            chk({tag, " result"}, bus.result, exp);
            chk({tag, " wb_addr"}, bus.wb_addr, rd);
            chk({tag, " wb_we"}, bus.wb_we, (rd != 0));
        end
    endtask

    task automatic idle_gap(input int n);
        @(posedge clk); #1;
        chk("done_single_cycle", bus.done, 0);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic run_flush(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int flush_k);
        logic [31:0] prev;
        bit seen;
        prev = bus.result;
        bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = 5'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (flush_k) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.start = 1'b0;
        chk("flush busy", bus.busy, 0);
        chk("flush done", bus.done, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        chk("flush no_done", seen, 0);
        chk("flush result_held", bus.result, prev);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_addr = '0; bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.result, 0);
        chk("reset wb_addr", bus.wb_addr, 0);
        chk("reset wb_we", bus.wb_we, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, -1);
        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, -1);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, -1);
        run_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd6, 32'hFFFF_FFFF, -1);
        run_op("mulhsu_pos", 3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 5'd6, 32'h0000_0001, -1);
        idle_gap(2);
        run_op("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, -1);
        run_op("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, -1);
        run_op("divu_100/7", 3'd5, 32'd100, 32'd7, 5'd12, 32'd14, -1);
        run_op("remu_100/7", 3'd7, 32'd100, 32'd7, 5'd13, 32'd2, -1);
        run_op("rem_7/-2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'd1, -1);
        run_op("div0", 3'd4, 32'd5, 32'd0, 5'd15, 32'hFFFF_FFFF, -1);
        run_op("remu0", 3'd7, 32'd5, 32'd0, 5'd16, 32'd5, -1);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, -1);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, -1);
        run_op("rd_zero", 3'd5, 32'd100, 32'd7, 5'd0, 32'd14, -1);
        idle_gap(1);
        run_op("start_in_calc", 3'd5, 32'd1000, 32'd9, 5'd20, 32'd111, 3);
        idle_gap(1);
        run_flush(3'd0, 32'd123, 32'd456, 5);

        // Asynchronous reset in the middle of a divide.
        bus.op = 3'd4; bus.rs1_data = 32'hFFFF_FFF9; bus.rs2_data = 32'd2; bus.rd_addr = 5'd8; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        chk("midcalc_reset busy", bus.busy, 0);
        chk("midcalc_reset done", bus.done, 0);
        chk("midcalc_reset result", bus.result, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        run_op("after_reset", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, -1);

        for (int i = 0; i < 30; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int          kind;
            op   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            if (kind == 0) b = 32'd0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) b = 32'($urandom_range(1, 20));
            else if (kind == 3) begin a = -32'($urandom_range(0, 1000)); b = -32'($urandom_range(1, 50)); end
            run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, rd, ref_md(op, a, b), -1);
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
